// File: rtl/twowire_dtm_apb_bridge.sv
// twowire_dtm_apb_bridge
// Takes word requests from the DTM core over a valid/ready handshake and runs
// APB3 transfers on one of N_PORTS downstream ports. The top W_SEL address
// bits choose the port. The bridge adds address auto-increment, a bus timeout
// and a sticky error flag. While that flag is set, bus traffic is blocked.
//
// Ports
//   dck, drst            clock and synchronous active-high reset
//   addr_load, addr_in   load the address register while idle
//   req_*                request channel from the DTM core
//   rsp_*                response channel back to the DTM core
//   sticky_err, clr_err  sticky error flag and its clear
//   cur_addr             current address register
//   dst_p*               shared APB master outputs, with one psel bit per port
//   dst_pready/pslverr/prdata   per-port APB slave inputs
module twowire_dtm_apb_bridge #(
    parameter int ASIZE   = 0,
    parameter int N_PORTS = 2,
    parameter int TIMEOUT = 255,
    parameter int AUTOINC = 1,
    localparam int AW     = 8 * (1 + ASIZE)
) (
    input  logic                  dck,
    input  logic                  drst,
    input  logic                  addr_load,
    input  logic [AW-1:0]         addr_in,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  sticky_err,
    input  logic                  clr_err,
    output logic [AW-1:0]         cur_addr,
    output logic [AW-1:0]         dst_paddr,
    output logic [N_PORTS-1:0]    dst_psel,
    output logic                  dst_penable,
    output logic                  dst_pwrite,
    output logic [31:0]           dst_pwdata,
    input  logic [N_PORTS-1:0]    dst_pready,
    input  logic [N_PORTS-1:0]    dst_pslverr,
    input  logic [32*N_PORTS-1:0] dst_prdata
);

    localparam int W_SEL = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [W_SEL-1:0]     port_q, port_d;
    logic                 req_rdy_q, req_rdy_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 sticky_q, sticky_d;
    logic [AW-1:0]        cur_addr_q, cur_addr_d;
    logic [AW-1:0]        paddr_q, paddr_d;
    logic [N_PORTS-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;

    logic                 accept;
    logic [AW-1:0]        req_addr;
    logic [W_SEL-1:0]     req_port;
    logic                 port_ok;
    logic                 sel_ready;
    logic                 sel_slverr;
    logic [31:0]          sel_rdata;
    logic                 rsp_enter;

    // Next-state logic. Every path that enters RESP raises rsp_enter. That
    // single point drives the address increment and the sticky-error set.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        port_d        = port_q;
        rsp_vld_d     = rsp_vld_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        sticky_d      = sticky_q;
        cur_addr_d    = cur_addr_q;
        paddr_d       = paddr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_enter     = 1'b0;

        // A load in the same cycle as an accepted request redirects that request.
        accept     = req_vld && req_rdy_q;
        req_addr   = addr_load ? addr_in : cur_addr_q;
        req_port   = req_addr[AW-1 -: W_SEL];
        port_ok    = (int'(req_port) < N_PORTS);
        sel_ready  = dst_pready[port_q];
        sel_slverr = dst_pslverr[port_q];
        sel_rdata  = dst_prdata[int'(port_q) * 32 +: 32];

        case (state_q)
            IDLE: begin
                if (addr_load) begin
                    cur_addr_d = addr_in;
                end
                if (accept) begin
                    cnt_d      = '0;
                    port_d     = req_port;
                    cur_addr_d = req_addr;
                    if (sticky_q || !port_ok) begin
                        // Blocked or unmapped: answer at once, never touch the bus.
                        state_d       = RESP;
                        rsp_enter     = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = N_PORTS'(1) << req_port;
                        paddr_d  = req_addr;
                        pwrite_d = req_write;
                        pwdata_d = req_wdata;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_err_d     = sel_slverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !sel_slverr) ? sel_rdata : 32'h0;
                    rsp_enter     = 1'b1;
                    state_d       = RESP;
                end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_C) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_enter     = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d = '0;
                if (rsp_rdy) begin
                    rsp_vld_d     = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp_enter) begin
            rsp_vld_d = 1'b1;
            if (AUTOINC != 0) begin
                cur_addr_d = cur_addr_d + AW'(4);
            end
        end

        // When a clear and a set land in the same cycle, the set wins.
        if (clr_err) begin
            sticky_d = 1'b0;
        end
        if (rsp_enter && rsp_err_d) begin
            sticky_d = 1'b1;
        end

        req_rdy_d = (state_d == IDLE);
    end

    // Every output comes from a flop here. Reset clears them all, even mid-transfer.
    always_ff @(posedge dck) begin
        if (drst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            port_q        <= '0;
            req_rdy_q     <= 1'b0;
            rsp_vld_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= 1'b0;
            cur_addr_q    <= '0;
            paddr_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            req_rdy_q     <= req_rdy_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            sticky_q      <= sticky_d;
            cur_addr_q    <= cur_addr_d;
            paddr_q       <= paddr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign req_rdy     = req_rdy_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign sticky_err  = sticky_q;
    assign cur_addr    = cur_addr_q;
    assign dst_paddr   = paddr_q;
    assign dst_psel    = psel_q;
    assign dst_penable = penable_q;
    assign dst_pwrite  = pwrite_q;
    assign dst_pwdata  = pwdata_q;

endmodule

// File: tb/tb_twowire_dtm_apb_bridge.sv
// tb_twowire_dtm_apb_bridge
// Two bridge instances run from a shared clock and reset.
//   a: N_PORTS=2, TIMEOUT=255  (read/write timing, wait states, wrap, slave error, reset in ACCESS)
//   b: N_PORTS=3, TIMEOUT=4    (timeout, sticky blocking, unmapped port)
// Both instances use an 8-bit address, so the port index sits in the top address bits.
module tb_twowire_dtm_apb_bridge;

    logic dck = 1'b0;
    logic drst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 dck = ~dck;

    logic        a_addr_load, a_req_vld, a_req_rdy, a_req_write, a_rsp_vld, a_rsp_rdy;
    logic        a_rsp_err, a_rsp_timeout, a_sticky, a_clr_err, a_penable, a_pwrite;
    logic [7:0]  a_addr_in, a_cur_addr, a_paddr;
    logic [31:0] a_req_wdata, a_rsp_rdata, a_pwdata;
    logic [1:0]  a_psel, a_pready, a_pslverr;
    logic [63:0] a_prdata;

    logic        b_addr_load, b_req_vld, b_req_rdy, b_req_write, b_rsp_vld, b_rsp_rdy;
    logic        b_rsp_err, b_rsp_timeout, b_sticky, b_clr_err, b_penable, b_pwrite;
    logic [7:0]  b_addr_in, b_cur_addr, b_paddr;
    logic [31:0] b_req_wdata, b_rsp_rdata, b_pwdata;
    logic [2:0]  b_psel, b_pready, b_pslverr;
    logic [95:0] b_prdata;

    twowire_dtm_apb_bridge #(.ASIZE(0), .N_PORTS(2), .TIMEOUT(255), .AUTOINC(1)) dut_a (
        .dck(dck), .drst(drst), .addr_load(a_addr_load), .addr_in(a_addr_in),
        .req_vld(a_req_vld), .req_rdy(a_req_rdy), .req_write(a_req_write), .req_wdata(a_req_wdata),
        .rsp_vld(a_rsp_vld), .rsp_rdy(a_rsp_rdy), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .rsp_timeout(a_rsp_timeout), .sticky_err(a_sticky), .clr_err(a_clr_err), .cur_addr(a_cur_addr),
        .dst_paddr(a_paddr), .dst_psel(a_psel), .dst_penable(a_penable), .dst_pwrite(a_pwrite),
        .dst_pwdata(a_pwdata), .dst_pready(a_pready), .dst_pslverr(a_pslverr), .dst_prdata(a_prdata)
    );

    twowire_dtm_apb_bridge #(.ASIZE(0), .N_PORTS(3), .TIMEOUT(4), .AUTOINC(1)) dut_b (
        .dck(dck), .drst(drst), .addr_load(b_addr_load), .addr_in(b_addr_in),
        .req_vld(b_req_vld), .req_rdy(b_req_rdy), .req_write(b_req_write), .req_wdata(b_req_wdata),
        .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_timeout(b_rsp_timeout), .sticky_err(b_sticky), .clr_err(b_clr_err), .cur_addr(b_cur_addr),
        .dst_paddr(b_paddr), .dst_psel(b_psel), .dst_penable(b_penable), .dst_pwrite(b_pwrite),
        .dst_pwdata(b_pwdata), .dst_pready(b_pready), .dst_pslverr(b_pslverr), .dst_prdata(b_prdata)
    );

    // Step to just after the next rising edge so outputs are settled when sampled.
    task automatic tick;
        @(posedge dck);
        #1;
    endtask

    task automatic test_reset;
        a_addr_load = 0; a_addr_in = 0; a_req_vld = 0; a_req_write = 0; a_req_wdata = 0;
        a_rsp_rdy = 0; a_clr_err = 0; a_pready = 2'b11; a_pslverr = 0; a_prdata = 0;
        b_addr_load = 0; b_addr_in = 0; b_req_vld = 0; b_req_write = 0; b_req_wdata = 0;
        b_rsp_rdy = 0; b_clr_err = 0; b_pready = 3'b111; b_pslverr = 0; b_prdata = 0;
        drst = 1;
        tick; tick;
        checks++;
        if ({a_req_rdy, a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_penable, a_pwrite, a_psel} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL reset_a_flags: got %h, expected 0",
                     {a_req_rdy, a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_penable, a_pwrite, a_psel});
        end
        checks++;
        if ({a_cur_addr, a_paddr, a_rsp_rdata, a_pwdata} !== 80'h0) begin
            errors++;
            $display("[TB] FAIL reset_a_data: got %h, expected 0", {a_cur_addr, a_paddr, a_rsp_rdata, a_pwdata});
        end
        checks++;
        if ({b_req_rdy, b_rsp_vld, b_rsp_err, b_rsp_timeout, b_sticky, b_penable, b_pwrite, b_psel} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL reset_b_flags: got %h, expected 0",
                     {b_req_rdy, b_rsp_vld, b_rsp_err, b_rsp_timeout, b_sticky, b_penable, b_pwrite, b_psel});
        end
        checks++;
        if ({b_cur_addr, b_paddr, b_rsp_rdata, b_pwdata} !== 80'h0) begin
            errors++;
            $display("[TB] FAIL reset_b_data: got %h, expected 0", {b_cur_addr, b_paddr, b_rsp_rdata, b_pwdata});
        end
        drst = 0;
        for (int i = 0; i < 5 && !(a_req_rdy && b_req_rdy); i++) tick;
        checks++;
        if ({a_req_rdy, b_req_rdy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, expected 11", {a_req_rdy, b_req_rdy});
        end
    endtask

    task automatic test_zero_wait_read;
        a_addr_load = 1; a_addr_in = 8'h10;
        tick;
        a_addr_load = 0;
        checks++;
        if (a_cur_addr !== 8'h10) begin
            errors++; $display("[TB] FAIL zw_load: got %h, expected 10", a_cur_addr);
        end
        a_pready = 2'b11; a_pslverr = 0; a_prdata = {32'h1111_2222, 32'hCAFE_F00D};
        a_req_write = 0; a_req_vld = 1;
        tick;
        a_req_vld = 0;
        checks++;
        if ({a_psel, a_penable, a_paddr, a_pwrite, a_req_rdy} !== {2'b01, 1'b0, 8'h10, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zw_setup: got %h, expected %h",
                     {a_psel, a_penable, a_paddr, a_pwrite, a_req_rdy}, {2'b01, 1'b0, 8'h10, 1'b0, 1'b0});
        end
        tick;
        checks++;
        if ({a_psel, a_penable, a_rsp_vld} !== 4'b0110) begin
            errors++; $display("[TB] FAIL zw_access: got %b, expected 0110", {a_psel, a_penable, a_rsp_vld});
        end
        tick;
        checks++;
        if ({a_rsp_vld, a_rsp_err, a_rsp_timeout, a_psel, a_penable} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL zw_resp: got %b, expected 100000", {a_rsp_vld, a_rsp_err, a_rsp_timeout, a_psel, a_penable});
        end
        checks++;
        if (a_rsp_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL zw_rdata: got %h, expected cafef00d", a_rsp_rdata);
        end
        checks++;
        if (a_cur_addr !== 8'h14) begin
            errors++; $display("[TB] FAIL zw_incr: got %h, expected 14", a_cur_addr);
        end
        a_rsp_rdy = 1;
        tick;
        a_rsp_rdy = 0;
        checks++;
        if ({a_rsp_vld, a_req_rdy} !== 2'b01) begin
            errors++; $display("[TB] FAIL zw_release: got %b, expected 01", {a_rsp_vld, a_req_rdy});
        end
    endtask

    task automatic test_wait_states;
        int psel_cnt = 0;
        int pen_cnt = 0;
        bit done = 0;
        a_addr_load = 1; a_addr_in = 8'h80;
        tick;
        a_addr_load = 0;
        a_pready = 2'b00; a_req_write = 1; a_req_wdata = 32'h1234_5678; a_req_vld = 1;
        tick;
        a_req_vld = 0;
        checks++;
        if ({a_psel, a_penable, a_paddr, a_pwrite, a_pwdata} !== {2'b10, 1'b0, 8'h80, 1'b1, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL ws_setup: got %h, expected %h",
                     {a_psel, a_penable, a_paddr, a_pwrite, a_pwdata}, {2'b10, 1'b0, 8'h80, 1'b1, 32'h1234_5678});
        end
        for (int i = 0; i < 20 && !done; i++) begin
            if (a_rsp_vld) begin
                done = 1;
            end else begin
                if (a_psel[1]) psel_cnt++;
                if (a_penable) pen_cnt++;
                if (a_penable && pen_cnt == 6) a_pready = 2'b10;
                tick;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("[TB] FAIL ws_done: got no response, expected rsp_vld within 20 cycles");
        end
        checks++;
        if (psel_cnt != 7 || pen_cnt != 6) begin
            errors++; $display("[TB] FAIL ws_counts: got psel %0d penable %0d, expected 7 and 6", psel_cnt, pen_cnt);
        end
        checks++;
        if ({a_rsp_err, a_rsp_timeout, a_rsp_rdata, a_cur_addr} !== {2'b00, 32'h0, 8'h84}) begin
            errors++;
            $display("[TB] FAIL ws_resp: got %h, expected %h", {a_rsp_err, a_rsp_timeout, a_rsp_rdata, a_cur_addr}, {2'b00, 32'h0, 8'h84});
        end
        a_pready = 2'b11;
        a_rsp_rdy = 1;
        tick;
        a_rsp_rdy = 0;
    endtask

    task automatic test_wrap_backpressure;
        a_addr_load = 1; a_addr_in = 8'hFC;
        tick;
        a_addr_load = 0;
        a_pready = 2'b11; a_prdata = {32'hA5A5_0001, 32'h0}; a_req_write = 0; a_req_vld = 1;
        tick;
        a_req_vld = 0;
        tick; tick;
        checks++;
        if ({a_rsp_vld, a_rsp_err, a_rsp_rdata, a_cur_addr} !== {2'b10, 32'hA5A5_0001, 8'h00}) begin
            errors++;
            $display("[TB] FAIL wrap_resp: got %h, expected %h", {a_rsp_vld, a_rsp_err, a_rsp_rdata, a_cur_addr}, {2'b10, 32'hA5A5_0001, 8'h00});
        end
        for (int i = 0; i < 3; i++) begin
            a_prdata = {32'hDEAD_BEE0 + 32'(i), 32'h0};
            tick;
            checks++;
            if ({a_rsp_vld, a_rsp_err, a_rsp_timeout, a_rsp_rdata, a_cur_addr} !== {3'b100, 32'hA5A5_0001, 8'h00}) begin
                errors++;
                $display("[TB] FAIL wrap_hold%0d: got %h, expected %h", i,
                         {a_rsp_vld, a_rsp_err, a_rsp_timeout, a_rsp_rdata, a_cur_addr}, {3'b100, 32'hA5A5_0001, 8'h00});
            end
        end
        a_rsp_rdy = 1;
        tick;
        a_rsp_rdy = 0;
        checks++;
        if (a_rsp_vld !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_release: got %b, expected 0", a_rsp_vld);
        end
    endtask

    task automatic test_slave_error;
        a_pslverr = 2'b01; a_prdata = {32'h0, 32'h55AA_55AA}; a_req_write = 0; a_req_vld = 1;
        tick;
        a_req_vld = 0;
        tick; tick;
        checks++;
        if ({a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_rsp_rdata} !== {4'b1101, 32'h0}) begin
            errors++;
            $display("[TB] FAIL slverr_resp: got %h, expected %h", {a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_rsp_rdata}, {4'b1101, 32'h0});
        end
        a_pslverr = 0;
        a_rsp_rdy = 1;
        tick;
        a_rsp_rdy = 0;
    endtask

    task automatic test_timeout;
        int pen_cnt = 0;
        bit done = 0;
        b_addr_load = 1; b_addr_in = 8'h00;
        tick;
        b_addr_load = 0;
        b_pready = 3'b000; b_req_write = 0; b_req_vld = 1;
        tick;
        b_req_vld = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (b_rsp_vld) begin
                done = 1;
            end else begin
                if (b_penable) pen_cnt++;
                tick;
            end
        end
        checks++;
        if (!done || pen_cnt != 5) begin
            errors++; $display("[TB] FAIL to_access_len: got done %0d access %0d, expected 1 and 5", done, pen_cnt);
        end
        checks++;
        if ({b_rsp_err, b_rsp_timeout, b_sticky, b_psel, b_penable, b_rsp_rdata, b_cur_addr} !== {3'b111, 3'b000, 1'b0, 32'h0, 8'h04}) begin
            errors++;
            $display("[TB] FAIL to_resp: got %h, expected %h", {b_rsp_err, b_rsp_timeout, b_sticky, b_psel, b_penable, b_rsp_rdata, b_cur_addr},
                     {3'b111, 3'b000, 1'b0, 32'h0, 8'h04});
        end
        b_pready = 3'b111;
        b_rsp_rdy = 1;
        tick;
        b_rsp_rdy = 0;
    endtask

    task automatic test_sticky_block;
        logic [2:0] seen = 3'b000;
        bit done = 0;
        b_addr_load = 1; b_addr_in = 8'h40;
        tick;
        b_addr_load = 0;
        b_req_write = 1; b_req_wdata = 32'hBEEF_0001; b_req_vld = 1;
        tick;
        b_req_vld = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            seen = seen | b_psel;
            if (b_rsp_vld) done = 1; else tick;
        end
        checks++;
        if ({done, seen, b_rsp_err, b_rsp_timeout, b_sticky, b_cur_addr} !== {1'b1, 3'b000, 3'b101, 8'h44}) begin
            errors++;
            $display("[TB] FAIL sticky_blocked: got %h, expected %h", {done, seen, b_rsp_err, b_rsp_timeout, b_sticky, b_cur_addr},
                     {1'b1, 3'b000, 3'b101, 8'h44});
        end
        b_rsp_rdy = 1;
        tick;
        b_rsp_rdy = 0;
        b_clr_err = 1;
        tick;
        b_clr_err = 0;
        checks++;
        if (b_sticky !== 1'b0) begin
            errors++; $display("[TB] FAIL sticky_clear: got %b, expected 0", b_sticky);
        end
        seen = 3'b000; done = 0;
        b_req_vld = 1;
        tick;
        b_req_vld = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            seen = seen | b_psel;
            if (b_rsp_vld) done = 1; else tick;
        end
        checks++;
        if ({done, seen, b_rsp_err, b_rsp_timeout, b_sticky, b_cur_addr} !== {1'b1, 3'b010, 3'b000, 8'h48}) begin
            errors++;
            $display("[TB] FAIL sticky_retry: got %h, expected %h", {done, seen, b_rsp_err, b_rsp_timeout, b_sticky, b_cur_addr},
                     {1'b1, 3'b010, 3'b000, 8'h48});
        end
        b_rsp_rdy = 1;
        tick;
        b_rsp_rdy = 0;
    endtask

    task automatic test_bad_port;
        // The load, request and clear all land in one cycle; the error set must win.
        b_addr_load = 1; b_addr_in = 8'hC0; b_clr_err = 1; b_req_write = 0; b_req_vld = 1;
        tick;
        b_addr_load = 0; b_clr_err = 0; b_req_vld = 0;
        checks++;
        if ({b_rsp_vld, b_rsp_err, b_rsp_timeout, b_sticky, b_psel, b_penable} !== 8'b1101_0000) begin
            errors++;
            $display("[TB] FAIL badport_resp: got %b, expected 11010000", {b_rsp_vld, b_rsp_err, b_rsp_timeout, b_sticky, b_psel, b_penable});
        end
        checks++;
        if ({b_cur_addr, b_rsp_rdata} !== {8'hC4, 32'h0}) begin
            errors++; $display("[TB] FAIL badport_addr: got %h, expected %h", {b_cur_addr, b_rsp_rdata}, {8'hC4, 32'h0});
        end
        b_rsp_rdy = 1;
        tick;
        b_rsp_rdy = 0;
    endtask

    task automatic test_reset_in_access;
        a_clr_err = 1;
        tick;
        a_clr_err = 0;
        a_addr_load = 1; a_addr_in = 8'h10;
        tick;
        a_addr_load = 0;
        a_pready = 2'b00; a_req_write = 0; a_req_vld = 1;
        tick;
        a_req_vld = 0;
        tick;
        checks++;
        if ({a_psel, a_penable, a_sticky} !== 4'b0110) begin
            errors++; $display("[TB] FAIL rst_in_access_pre: got %b, expected 0110", {a_psel, a_penable, a_sticky});
        end
        drst = 1;
        tick;
        checks++;
        if ({a_req_rdy, a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_penable, a_pwrite, a_psel} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL rst_in_access_flags: got %h, expected 0",
                     {a_req_rdy, a_rsp_vld, a_rsp_err, a_rsp_timeout, a_sticky, a_penable, a_pwrite, a_psel});
        end
        checks++;
        if ({a_cur_addr, a_paddr, a_rsp_rdata, a_pwdata} !== 80'h0) begin
            errors++; $display("[TB] FAIL rst_in_access_data: got %h, expected 0", {a_cur_addr, a_paddr, a_rsp_rdata, a_pwdata});
        end
        drst = 0;
        a_pready = 2'b11;
        tick;
    endtask

    initial begin
        test_reset;
        test_zero_wait_read;
        test_wait_states;
        test_wrap_backpressure;
        test_slave_error;
        test_timeout;
        test_sticky_block;
        test_bad_port;
        test_reset_in_access;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
